// File: rtl/asteroids_input_cond_if.sv
// Joystick-in / cabinet-button-out bundle for asteroids_input_cond.
interface asteroids_input_cond_if;
  logic [15:0] joy_0;
  logic [15:0] joy_1;
  logic [7:0]  BUTTON;
  logic        coin_busy;

  modport master (output joy_0, joy_1, input BUTTON, coin_busy);
  modport slave  (input joy_0, joy_1, output BUTTON, coin_busy);
endinterface

// File: rtl/asteroids_input_cond.sv
// HPS joystick words -> active-low Asteroids cabinet button bus (clk_25 domain).
// Optional autofire on BUTTON[3] is built when ASTEROIDS_AUTOFIRE_EN is defined.
module asteroids_input_cond #(
  parameter int TICK_DIV    = 25000,
  parameter int COIN_MS     = 50,
  parameter int COIN_GAP_MS = 50,
  parameter int START_MS    = 20,
  parameter int QUEUE_MAX   = 3
`ifdef ASTEROIDS_AUTOFIRE_EN
  , parameter int AUTOFIRE_MS = 60
`endif
) (
  input  logic                   clk_25,
  input  logic                   RESET_L,
  asteroids_input_cond_if.slave  io_bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] QMAX = 2'(QUEUE_MAX);

  // synced vector layout
  localparam int S_RIGHT = 0, S_LEFT = 1, S_FIRE = 2, S_THRUST = 3;
  localparam int S_HYPER = 4, S_ST1 = 5, S_ST2 = 6, S_COIN = 7;
`ifdef ASTEROIDS_AUTOFIRE_EN
  localparam int S_AUTO = 8;
  localparam int NS = 9;
  localparam int AF_HALF = (AUTOFIRE_MS / 2 < 1) ? 1 : AUTOFIRE_MS / 2;
`else
  localparam int NS = 8;
`endif

  if (COIN_MS > 255 || COIN_GAP_MS > 255 || START_MS > 255) begin : g_param_err
    $error("asteroids_input_cond: timer parameters must fit in 8 bits");
  end
`ifdef ASTEROIDS_AUTOFIRE_EN
  if (AF_HALF > 255) begin : g_af_param_err
    $error("asteroids_input_cond: AUTOFIRE_MS/2 must fit in 8 bits");
  end
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

  logic [15:0]   w_j;
  logic [NS-1:0] w_raw, r_sync1, r_sync2;
  logic          w_unused;

  assign w_j = io_bus.joy_0 | io_bus.joy_1;
  assign w_raw[7:0] = {w_j[9], w_j[8], w_j[7], w_j[6], w_j[5], w_j[4], w_j[1], w_j[0]};
`ifdef ASTEROIDS_AUTOFIRE_EN
  assign w_raw[S_AUTO] = w_j[10];
  assign w_unused = ^{w_j[15:11], w_j[3:2]};
`else
  assign w_unused = ^{w_j[15:10], w_j[3:2]};
`endif

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // 1 ms tick
  logic [PW-1:0] r_presc;
  logic          w_tick;
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // start stretch, lane 0 = start1 (j7), lane 1 = start2 (j8)
  logic [1:0]      w_st_sync, r_st_prev, w_st_rise, w_st_on;
  logic [1:0][7:0] r_st_cnt;
  assign w_st_sync = {r_sync2[S_ST2], r_sync2[S_ST1]};
  assign w_st_rise = w_st_sync & ~r_st_prev;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_st_prev <= '0;
      r_st_cnt  <= '0;
    end else begin
      r_st_prev <= w_st_sync;
      for (int i = 0; i < 2; i++) begin
        if (w_st_rise[i])                     r_st_cnt[i] <= 8'(START_MS);
        else if (w_tick && r_st_cnt[i] != '0) r_st_cnt[i] <= r_st_cnt[i] - 8'd1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_st_on
    assign w_st_on[g] = w_st_sync[g] | (r_st_cnt[g] != '0);
  end

  // coin edge detect + FSM
  logic       r_coin_prev, w_coin_req;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_timer;
  logic [1:0] r_queue;
  logic       w_coin_on, w_busy;

  assign w_coin_req = r_sync2[S_COIN] & ~r_coin_prev;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state     <= IDLE;
      r_coin_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_coin_prev <= r_sync2[S_COIN];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_coin_req || r_queue != '0) w_state_nxt = PULSE;
      PULSE:   if (r_timer == '0) w_state_nxt = GAP;
      GAP:     if (r_timer == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_coin_on = (r_state == PULSE);
    w_busy    = (r_state != IDLE) || (r_queue != '0);
  end

  // timer counts ms ticks; a fresh request in IDLE wins over a queued one
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_timer <= '0;
      r_queue <= '0;
    end else begin
      case (r_state)
        IDLE:  if (w_state_nxt == PULSE) r_timer <= 8'(COIN_MS);
        PULSE: if (r_timer == '0) r_timer <= 8'(COIN_GAP_MS);
               else if (w_tick)   r_timer <= r_timer - 8'd1;
        GAP:   if (r_timer != '0 && w_tick) r_timer <= r_timer - 8'd1;
        default: r_timer <= '0;
      endcase
      if (r_state == IDLE) begin
        if (!w_coin_req && r_queue != '0) r_queue <= r_queue - 2'd1;
      end else if (w_coin_req && r_queue != QMAX) begin
        r_queue <= r_queue + 2'd1;
      end
    end
  end

  // fire: plain or autofire
  logic w_fire_on;
`ifdef ASTEROIDS_AUTOFIRE_EN
  logic       r_fire_prev, r_af_phase, w_fire_rise;
  logic [7:0] r_af_cnt;
  assign w_fire_rise = r_sync2[S_FIRE] & ~r_fire_prev;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_fire_prev <= 1'b0;
      r_af_phase  <= 1'b0;
      r_af_cnt    <= '0;
    end else begin
      r_fire_prev <= r_sync2[S_FIRE];
      if (w_fire_rise) begin
        r_af_phase <= 1'b1;
        r_af_cnt   <= 8'(AF_HALF);
      end else if (r_sync2[S_FIRE] && w_tick) begin
        if (r_af_cnt <= 8'd1) begin
          r_af_phase <= ~r_af_phase;
          r_af_cnt   <= 8'(AF_HALF);
        end else begin
          r_af_cnt <= r_af_cnt - 8'd1;
        end
      end
    end
  end

  // the press cycle itself is asserted even though the phase flop loads one edge later
  assign w_fire_on = r_sync2[S_FIRE] & (~r_sync2[S_AUTO] | w_fire_rise | r_af_phase);
`else
  assign w_fire_on = r_sync2[S_FIRE];
`endif

  logic [7:0] r_button;
  logic       r_busy;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_button <= 8'hFF;
      r_busy   <= 1'b0;
    end else begin
      r_button <= ~{r_sync2[S_RIGHT], r_sync2[S_LEFT], w_st_on[0], w_st_on[1],
                    w_fire_on, w_coin_on, r_sync2[S_THRUST], r_sync2[S_HYPER]};
      r_busy   <= w_busy;
    end
  end

  assign io_bus.BUTTON    = r_button;
  assign io_bus.coin_busy = r_busy;

endmodule

// File: tb/tb_asteroids_input_cond.sv
// Directed bench for asteroids_input_cond with pulse-width scoreboard on BUTTON[2] and BUTTON[5].
module tb_asteroids_input_cond;

  logic clk_25 = 1'b0;
  logic RESET_L = 1'b0;
  always #5 clk_25 = ~clk_25;

  asteroids_input_cond_if io();

  asteroids_input_cond #(
    .TICK_DIV(10), .COIN_MS(4), .COIN_GAP_MS(3), .START_MS(2), .QUEUE_MAX(3)
`ifdef ASTEROIDS_AUTOFIRE_EN
    , .AUTOFIRE_MS(4)
`endif
  ) dut (
    .clk_25 (clk_25),
    .RESET_L(RESET_L),
    .io_bus (io)
  );

  typedef struct { int lo; int hi; bit gap_chk; } exp_t;
  exp_t coin_q[$];
  exp_t st_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int run_c = 0, gap_c = 0, start_gap = 0, coin_pulses = 0;
  int run_s = 0, st_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // one clock; samples on the falling edge and scores finished low runs
  task automatic step();
    exp_t e;
    @(negedge clk_25);
    if (io.BUTTON[2] === 1'b0) begin
      if (run_c == 0) begin
        start_gap = gap_c;
        gap_c = 0;
      end
      run_c++;
    end else begin
      if (run_c > 0) begin
        coin_pulses++;
        if (coin_q.size() == 0) chk("coin_unexpected_pulse_len", run_c, 0);
        else begin
          e = coin_q.pop_front();
          chk_rng("coin_width", run_c, e.lo, e.hi);
          if (e.gap_chk) chk_rng("coin_gap", start_gap, 20, 100000);
        end
      end
      run_c = 0;
      gap_c++;
    end
    if (io.BUTTON[5] === 1'b0) run_s++;
    else begin
      if (run_s > 0) begin
        st_pulses++;
        if (st_q.size() == 0) chk("start_unexpected_pulse_len", run_s, 0);
        else begin
          e = st_q.pop_front();
          chk_rng("start_width", run_s, e.lo, e.hi);
        end
      end
      run_s = 0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    int len;
    io.joy_0 = '0;
    io.joy_1 = '0;

    // reset
    steps(3);
    chk("reset_button", io.BUTTON, 8'hFF);
    chk("reset_busy", io.coin_busy, 1'b0);
    RESET_L = 1'b1;
    steps(2);
    chk("post_reset_button", io.BUTTON, 8'hFF);
    chk("post_reset_busy", io.coin_busy, 1'b0);

    // direct path latency
    io.joy_0 = 16'h0001;
    step(); chk("lat_cyc1", io.BUTTON, 8'hFF);
    step(); chk("lat_cyc2", io.BUTTON, 8'hFF);
    step(); chk("lat_cyc3", io.BUTTON, 8'h7F);
    io.joy_0 = '0;
    io.joy_1 = 16'h0072;
    steps(3); chk("direct_p1", io.BUTTON, 8'hB4);
    io.joy_1 = 16'h040C;
    steps(3); chk("ignored_bits", io.BUTTON, 8'hFF);
    io.joy_1 = 16'h0100;
    steps(3); chk("start2_held", io.BUTTON, 8'hEF);
    io.joy_1 = '0;
    steps(30); chk("idle_after_direct", io.BUTTON, 8'hFF);

    // single held coin
    base = coin_pulses;
    coin_q.push_back('{31, 41, 1'b0});
    io.joy_1 = 16'h0200;
    steps(10); chk("coin_busy_during", io.coin_busy, 1'b1);
    steps(490);
    chk("single_coin_count", coin_pulses - base, 1);
    chk("single_coin_busy_end", io.coin_busy, 1'b0);
    io.joy_1 = '0;
    steps(5);

    // five taps inside one pulse: one live + three queued, fifth dropped
    base = coin_pulses;
    coin_q.push_back('{31, 41, 1'b0});
    repeat (3) coin_q.push_back('{31, 41, 1'b1});
    for (int t = 0; t < 5; t++) begin
      io.joy_0 = 16'h0200; steps(2);
      io.joy_0 = '0;       steps(5);
    end
    steps(400);
    chk("queue_coin_count", coin_pulses - base, 4);
    chk("queue_scoreboard_empty", coin_q.size(), 0);
    chk("queue_busy_end", io.coin_busy, 1'b0);

    // start stretch, then retrigger 8 cycles after the first tap
    base = st_pulses;
    st_q.push_back('{11, 21, 1'b0});
    io.joy_0 = 16'h0080; step();
    io.joy_0 = '0;       steps(40);
    st_q.push_back('{19, 29, 1'b0});
    io.joy_0 = 16'h0080; step();
    io.joy_0 = '0;       steps(7);
    io.joy_0 = 16'h0080; step();
    io.joy_0 = '0;       steps(40);
    chk("start_pulse_count", st_pulses - base, 2);
    chk("start_scoreboard_empty", st_q.size(), 0);

    // reset in the middle of a pulse with two coins queued
    base = coin_pulses;
    coin_q.push_back('{1, 41, 1'b0});
    for (int t = 0; t < 3; t++) begin
      io.joy_0 = 16'h0200; steps(2);
      io.joy_0 = '0;       steps(5);
    end
    chk("midpulse_coin_low", io.BUTTON[2], 1'b0);
    chk("midpulse_busy", io.coin_busy, 1'b1);
    #2 RESET_L = 1'b0;
    #1;
    chk("async_reset_button", io.BUTTON, 8'hFF);
    chk("async_reset_busy", io.coin_busy, 1'b0);
    steps(3);
    RESET_L = 1'b1;
    steps(400);
    chk("no_replay_count", coin_pulses - base, 1);
    chk("no_replay_busy", io.coin_busy, 1'b0);

    // fire with autofire select
    io.joy_0 = 16'h0410;
    steps(3);
    chk("fire_press_low", io.BUTTON, 8'hF7);
`ifdef ASTEROIDS_AUTOFIRE_EN
    len = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (io.BUTTON[3] !== 1'b0) break;
      len++;
    end
    chk_rng("af_first_low", len, 12, 21);
    len = 0;
    for (int i = 0; i < 60; i++) begin
      if (io.BUTTON[3] !== 1'b1) break;
      len++;
      step();
    end
    chk("af_high_half", len, 20);
    len = 0;
    for (int i = 0; i < 60; i++) begin
      if (io.BUTTON[3] !== 1'b0) break;
      len++;
      step();
    end
    chk("af_low_half", len, 20);
`else
    len = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (io.BUTTON[3] !== 1'b0) len++;
    end
    chk("fire_steady_highs", len, 0);
`endif
    io.joy_0 = '0;
    steps(3);
    chk("fire_release", io.BUTTON, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
